// File: rtl/lif_neuron_array.sv
// ============================================================================
// Module   : lif_neuron_array
// Purpose  : N_CH parallel leaky integrate-and-fire neurons with refractory
//            timers and a shared saturating spike counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lif_neuron_array #(
  parameter int WIDTH      = 8,
  parameter int N_CH       = 4,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [N_CH*WIDTH-1:0]  input_current,
  input  logic [WIDTH-1:0]       threshold,
  input  logic                   count_clr,
  output logic [N_CH-1:0]        spike,
  output logic [N_CH*WIDTH-1:0]  membrane,
  output logic [N_CH-1:0]        refractory,
  output logic [15:0]            spike_count
);

  localparam int              CNT_W    = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic [CNT_W-1:0] REF_LOAD = CNT_W'(REFRAC);

  logic [N_CH-1:0] spike_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [WIDTH-1:0] mem_q, mem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             spk_q, spk_d;
    logic [WIDTH-1:0] w_cur, w_leaked, w_sum_sat;
    logic [WIDTH:0]   w_sum;

    assign w_cur     = input_current[i*WIDTH +: WIDTH];
    assign w_leaked  = mem_q - (mem_q >> LEAK_SHIFT);
    assign w_sum     = {1'b0, w_leaked} + {1'b0, w_cur};
    assign w_sum_sat = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];

    always_comb begin
      mem_d = mem_q;
      cnt_d = cnt_q;
      spk_d = 1'b0;
      if (en) begin
        if (cnt_q != '0) begin
          // Refractory: membrane pinned at rest, input ignored.
          mem_d = '0;
          cnt_d = cnt_q - 1'b1;
        end else if (w_sum_sat >= threshold) begin
          mem_d = '0;
          cnt_d = REF_LOAD;
          spk_d = 1'b1;
        end else begin
          mem_d = w_sum_sat;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q <= '0;
        cnt_q <= '0;
        spk_q <= 1'b0;
      end else begin
        mem_q <= mem_d;
        cnt_q <= cnt_d;
        spk_q <= spk_d;
      end
    end

    assign spike_d[i]                   = spk_d;
    assign spike[i]                     = spk_q;
    assign refractory[i]                = (cnt_q != '0);
    assign membrane[i*WIDTH +: WIDTH]   = mem_q;
  end

  logic [16:0] w_pop;
  logic [16:0] w_count_sum;
  logic [15:0] count_d;
  logic [15:0] count_q;

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_pop = w_pop + 17'(spike_d[k]);
    end
  end

  assign w_count_sum = {1'b0, count_q} + w_pop;

  // Clear wins over any spikes landing on the same edge.
  always_comb begin
    count_d = count_q;
    if (count_clr)           count_d = '0;
    else if (w_count_sum[16]) count_d = 16'hFFFF;
    else                     count_d = w_count_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign spike_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_lif_neuron_array.sv
// ============================================================================
// Module   : tb_lif_neuron_array
// Purpose  : Directed self-checking bench for lif_neuron_array.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lif_neuron_array;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] input_current;
  logic [7:0]  threshold;
  logic        count_clr;
  logic [3:0]  spike;
  logic [31:0] membrane;
  logic [3:0]  refractory;
  logic [15:0] spike_count;

  // Second instance without refractory, used for back-to-back firing and
  // counter saturation.
  logic        en2;
  logic [31:0] input_current2;
  logic [7:0]  threshold2;
  logic        count_clr2;
  logic [3:0]  spike2;
  logic [31:0] membrane2;
  logic [3:0]  refractory2;
  logic [15:0] spike_count2;

  int total = 0;
  int bad   = 0;

  lif_neuron_array #(.WIDTH(8), .N_CH(4), .LEAK_SHIFT(3), .REFRAC(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .input_current(input_current),
    .threshold(threshold), .count_clr(count_clr), .spike(spike),
    .membrane(membrane), .refractory(refractory), .spike_count(spike_count)
  );

  lif_neuron_array #(.WIDTH(8), .N_CH(4), .LEAK_SHIFT(3), .REFRAC(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .input_current(input_current2),
    .threshold(threshold2), .count_clr(count_clr2), .spike(spike2),
    .membrane(membrane2), .refractory(refractory2), .spike_count(spike_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; en2 = 1'b0; count_clr = 1'b0; count_clr2 = 1'b0;
    input_current = '0; input_current2 = '0;
    threshold = 8'h80; threshold2 = 8'h01;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0; en2 = 1'b0; count_clr = 1'b0; count_clr2 = 1'b0;
    input_current = '0; input_current2 = '0;
    threshold = 8'h80; threshold2 = 8'h01;
    #2;
    total++;
    if ({spike, membrane, refractory, spike_count} !== 56'h0) begin
      bad++;
      $display("FAIL reset_state: got spk=%h mem=%h ref=%h cnt=%h want all 0",
               spike, membrane, refractory, spike_count);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_integration();
    logic [7:0] exp_mem [10];
    logic       exp_spk [10];
    logic       exp_ref [10];
    exp_mem = '{8'h20, 8'h3C, 8'h55, 8'h6B, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20};
    exp_spk = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    exp_ref = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
    do_reset();
    threshold = 8'h80;
    input_current = 32'h0000_0020;
    en = 1'b1;
    for (int s = 0; s < 10; s++) begin
      tick();
      total++;
      if (membrane[7:0] !== exp_mem[s] || spike[0] !== exp_spk[s] ||
          refractory[0] !== exp_ref[s]) begin
        bad++;
        $display("FAIL integ step %0d: got mem=%h spk=%b ref=%b want mem=%h spk=%b ref=%b",
                 s, membrane[7:0], spike[0], refractory[0], exp_mem[s], exp_spk[s], exp_ref[s]);
      end
    end
    total++;
    if (membrane[31:8] !== 24'h0 || spike[3:1] !== 3'b0 || spike_count !== 16'd1) begin
      bad++;
      $display("FAIL integ_isolation: got mem_hi=%h spk=%b cnt=%0d want 0 000 1",
               membrane[31:8], spike, spike_count);
    end
    en = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    threshold = 8'hFF;
    input_current = 32'h0000_F000;
    en = 1'b1;
    tick();
    total++;
    if (membrane[15:8] !== 8'hF0 || spike[1] !== 1'b0) begin
      bad++;
      $display("FAIL sat_first: got mem=%h spk=%b want F0 0", membrane[15:8], spike[1]);
    end
    tick();
    total++;
    if (membrane[15:8] !== 8'h00 || spike !== 4'b0010) begin
      bad++;
      $display("FAIL sat_fire: got mem=%h spk=%b want 00 0010", membrane[15:8], spike);
    end
    en = 1'b0;
  endtask

  task automatic test_leak();
    logic [7:0] exp_mem [3];
    exp_mem = '{8'h38, 8'h31, 8'h2B};
    do_reset();
    threshold = 8'h80;
    input_current = 32'h0040_0000;
    en = 1'b1;
    tick();
    total++;
    if (membrane[23:16] !== 8'h40) begin
      bad++;
      $display("FAIL leak_load: got %h want 40", membrane[23:16]);
    end
    input_current = '0;
    for (int s = 0; s < 3; s++) begin
      tick();
      total++;
      if (membrane[23:16] !== exp_mem[s] || spike !== 4'b0) begin
        bad++;
        $display("FAIL leak step %0d: got mem=%h spk=%b want %h 0000",
                 s, membrane[23:16], spike, exp_mem[s]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_en_gating();
    do_reset();
    threshold = 8'h80;
    input_current = 32'h0000_0020;
    en = 1'b1;
    tick();
    tick();
    en = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      total++;
      if (membrane[7:0] !== 8'h3C || spike !== 4'b0 || refractory !== 4'b0) begin
        bad++;
        $display("FAIL gate_integ cyc %0d: got mem=%h spk=%b ref=%b want 3C 0000 0000",
                 s, membrane[7:0], spike, refractory);
      end
    end
    en = 1'b1;
    for (int s = 0; s < 4; s++) tick();
    total++;
    if (spike[0] !== 1'b1 || refractory[0] !== 1'b1) begin
      bad++;
      $display("FAIL gate_fire: got spk=%b ref=%b want 1 1", spike[0], refractory[0]);
    end
    en = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      total++;
      if (membrane[7:0] !== 8'h00 || spike !== 4'b0 || refractory[0] !== 1'b1) begin
        bad++;
        $display("FAIL gate_refrac cyc %0d: got mem=%h spk=%b ref=%b want 00 0000 1",
                 s, membrane[7:0], spike, refractory[0]);
      end
    end
    en = 1'b1;
    tick();
    tick();
    tick();
    total++;
    if (refractory[0] !== 1'b0 || membrane[7:0] !== 8'h00) begin
      bad++;
      $display("FAIL gate_resume: got ref=%b mem=%h want 0 00", refractory[0], membrane[7:0]);
    end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    threshold = 8'h80;
    input_current = 32'h0000_0020;
    en = 1'b1;
    for (int s = 0; s < 7; s++) tick();
    total++;
    if (refractory[0] !== 1'b1 || spike_count !== 16'd1) begin
      bad++;
      $display("FAIL arst_pre: got ref=%b cnt=%0d want 1 1", refractory[0], spike_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({spike, membrane, refractory, spike_count} !== 56'h0) begin
      bad++;
      $display("FAIL arst_clear: got spk=%h mem=%h ref=%h cnt=%h want all 0",
               spike, membrane, refractory, spike_count);
    end
    #1;
    rst_n = 1'b1;
    tick();
    total++;
    if (membrane[7:0] !== 8'h20 || refractory[0] !== 1'b0 || spike[0] !== 1'b0) begin
      bad++;
      $display("FAIL arst_resume: got mem=%h ref=%b spk=%b want 20 0 0",
               membrane[7:0], refractory[0], spike[0]);
    end
    en = 1'b0;
  endtask

  task automatic test_count();
    do_reset();
    threshold = 8'h00;
    input_current = '0;
    en = 1'b1;
    tick();
    total++;
    if (spike !== 4'hF || spike_count !== 16'd4) begin
      bad++;
      $display("FAIL count_all4: got spk=%b cnt=%0d want 1111 4", spike, spike_count);
    end
    for (int s = 0; s < 3; s++) tick();
    total++;
    if (spike !== 4'h0 || spike_count !== 16'd4 || refractory !== 4'h0) begin
      bad++;
      $display("FAIL count_refrac: got spk=%b cnt=%0d ref=%b want 0000 4 0000",
               spike, spike_count, refractory);
    end
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    total++;
    if (spike !== 4'hF || spike_count !== 16'd0) begin
      bad++;
      $display("FAIL count_clr_prio: got spk=%b cnt=%0d want 1111 0", spike, spike_count);
    end
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    threshold2 = 8'h01;
    input_current2 = 32'h0101_0101;
    en2 = 1'b1;
    tick();
    tick();
    total++;
    if (spike2 !== 4'hF || spike_count2 !== 16'd8 || refractory2 !== 4'h0) begin
      bad++;
      $display("FAIL b2b_fire: got spk=%b cnt=%0d ref=%b want 1111 8 0000",
               spike2, spike_count2, refractory2);
    end
    for (int s = 2; s < 16383; s++) tick();
    total++;
    if (spike_count2 !== 16'hFFFC) begin
      bad++;
      $display("FAIL sat_preload: got %h want FFFC", spike_count2);
    end
    input_current2 = 32'h0000_0101;
    tick();
    total++;
    if (spike_count2 !== 16'hFFFE || spike2 !== 4'b0011) begin
      bad++;
      $display("FAIL sat_fffe: got cnt=%h spk=%b want FFFE 0011", spike_count2, spike2);
    end
    tick();
    total++;
    if (spike_count2 !== 16'hFFFF) begin
      bad++;
      $display("FAIL sat_ffff: got %h want FFFF", spike_count2);
    end
    tick();
    total++;
    if (spike_count2 !== 16'hFFFF || spike2 !== 4'b0011) begin
      bad++;
      $display("FAIL sat_hold: got cnt=%h spk=%b want FFFF 0011", spike_count2, spike2);
    end
    en2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_integration();
    test_saturation();
    test_leak();
    test_en_gating();
    test_async_reset();
    test_count();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
